// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A 1-bit operand still needs a counter of at least one bit.
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_add_cell.sv
// Single-bit full adder; mirror of the fullsub datapath cell.
module full_add_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | adding one bit per clock, busy=1
// DONE  | one-cycle done pulse, sum/cout valid
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_sr_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s, fa_co;
   logic             accept, last;

   full_add_cell u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (fa_s),
      .co  (fa_co)
   );

   // Shift-based form keeps WIDTH=1 legal (no [WIDTH-1:1] slice).
   assign s_sr_nxt = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (busy) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         s_sr  <= s_sr_nxt;
         carry <= fa_co;
         cnt   <= cnt + 1'b1;
         // Results become visible only once fully assembled.
         if (last) begin
            sum  <= s_sr_nxt;
            cout <= fa_co;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a, b;
   logic       cin;
   logic       ready, busy, done, cout;
   logic [7:0] sum;

   logic       start1, a1, b1, cin1;
   logic       ready1, busy1, done1, sum1, cout1;

   int total = 0;
   int bad   = 0;

   logic [7:0] prev_sum  = 8'h00;
   logic       prev_cout = 1'b0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts an operation at the current falling edge (DUT must be idle) and
   // returns at the falling edge of the done cycle. poke_at >= 0 re-pulses
   // start with other operands in that busy cycle.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input int poke_at,
                        output int nbusy, output logic [7:0] rs, output logic rc,
                        output logic timeout, output logic held_ok, output logic rdy_ok);
      start = 1'b1; a = ta; b = tb_; cin = tc;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      nbusy = 0; timeout = 1'b1; held_ok = 1'b1; rdy_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            timeout = 1'b0;
            break;
         end
         if (busy) nbusy++;
         if (ready) rdy_ok = 1'b0;
         if (sum !== prev_sum || cout !== prev_cout) held_ok = 1'b0;
         start = (i == poke_at);
         if (i == poke_at) begin
            a = ~ta; b = tb_ ^ 8'h5A; cin = ~tc;
         end
         @(negedge clk);
      end
      start = 1'b0;
      rs = sum; rc = cout;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset_w8: got rdy/busy/done/cout/sum=%b%b%b%b/%h want 1000/00",
                  ready, busy, done, cout, sum);
      end
      total++;
      if ({ready1, busy1, done1, cout1, sum1} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_w1: got %b%b%b%b%b want 10000", ready1, busy1, done1, cout1, sum1);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs one operation and checks result, latency, done width, held outputs.
   task automatic test_vector(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                              input logic tc, input int poke_at);
      int         nbusy;
      logic [7:0] rs;
      logic       rc, to, held_ok, rdy_ok;
      logic [8:0] exp;
      exp = 9'(ta) + 9'(tb_) + 9'(tc);
      do_op(ta, tb_, tc, poke_at, nbusy, rs, rc, to, held_ok, rdy_ok);
      total++;
      if (to) begin
         bad++;
         $display("FAIL %s_timeout: no done within 40 cycles", name);
      end
      total++;
      if ({rc, rs} !== exp) begin
         bad++;
         $display("FAIL %s_result: a=%h b=%h cin=%b got {cout,sum}=%h want %h",
                  name, ta, tb_, tc, {rc, rs}, exp);
      end
      total++;
      if (nbusy !== 8) begin
         bad++;
         $display("FAIL %s_latency: got busy cycles=%0d want 8", name, nbusy);
      end
      total++;
      if (!held_ok || !rdy_ok) begin
         bad++;
         $display("FAIL %s_inflight: got held=%b ready_low=%b want 1 1", name, held_ok, rdy_ok);
      end
      prev_sum  = exp[7:0];
      prev_cout = exp[8];
      @(negedge clk);
      total++;
      if ({done, ready, busy} !== 3'b010) begin
         bad++;
         $display("FAIL %s_done_width: got done/ready/busy=%b%b%b want 010", name, done, ready, busy);
      end
   endtask

   task automatic test_directed();
      test_vector("basic",   8'h0F, 8'h01, 1'b0, -1);
      test_vector("wrap",    8'hFF, 8'h01, 1'b0, -1);
      test_vector("all_one", 8'hFF, 8'hFF, 1'b1, -1);
   endtask

   task automatic test_ignore_start();
      test_vector("ignore_start", 8'h3C, 8'h29, 1'b1, 2);
   endtask

   task automatic test_reset_mid();
      logic seen_done;
      start = 1'b1; a = 8'hA5; b = 8'h5B; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_busy_before: got busy=%b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL rstmid_async: got rdy/busy/done/cout/sum=%b%b%b%b/%h want 1000/00",
                  ready, busy, done, cout, sum);
      end
      prev_sum = 8'h00; prev_cout = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      total++;
      if (seen_done !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_no_done: got done pulse=%b want 0", seen_done);
      end
      test_vector("after_rst", 8'h80, 8'h7F, 1'b1, -1);
   endtask

   task automatic test_width1();
      logic [1:0] exp;
      int         ok;
      for (int v = 0; v < 8; v++) begin
         start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
         @(negedge clk);
         start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
         ok = (busy1 === 1'b1);
         @(negedge clk);
         exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         total++;
         if (!ok || done1 !== 1'b1 || {cout1, sum1} !== exp) begin
            bad++;
            $display("FAIL w1_vec%0d: got busy=%0d done=%b {cout,sum}=%b want 1 1 %b",
                     v, ok, done1, {cout1, sum1}, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 1000; n++) begin
         test_vector("rand", 8'($urandom), 8'($urandom), 1'($urandom), -1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_width1();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
